// File: rtl/agc_mon_pkg.sv
// Shared definitions for the AGC monitor-side MCT step sequencer.
// Holds the host command encodings and the controller state type.
package agc_mon_pkg;

    localparam logic [1:0] CMD_RUN     = 2'b00;
    localparam logic [1:0] CMD_STOP    = 2'b01;
    localparam logic [1:0] CMD_STEP    = 2'b10;
    localparam logic [1:0] CMD_RESTART = 2'b11;

    typedef enum logic [2:0] {
        RUNNING,
        STOPPING,
        HALTED,
        STEP_PULSE,
        STEP_WAIT,
        STEP_STOP,
        RESTART
    } mon_state_t;

endpackage

// File: rtl/agc_pulse_timer.sv
// Loadable down-counter: pulse is high while the count is nonzero.
// last flags the final cycle of the pulse so the owner can leave on time.
module agc_pulse_timer #(
    parameter int unsigned W = 8
) (
    input  logic         CLOCK,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         pulse,
    output logic         last
);

    logic [W-1:0] cnt;

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_comb begin
        pulse = (cnt != '0);
        last  = (cnt == W'(1));
    end

endmodule

// File: rtl/agc_mct_step_ctrl.sv
// Monitor sequencer driving the timer's MSTP/MSTRTP/STRT2 inputs from host
// commands, counting completed MCTs from T12 rises during a STEP.
module agc_mct_step_ctrl
    import agc_mon_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned STRT_PULSE = 4,
    parameter int unsigned RST_TMO    = 64
) (
    input  logic             CLOCK,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             T12,
    input  logic             STOPA,
    input  logic             GOJAM,
    output logic             MSTP,
    output logic             MSTRTP,
    output logic             STRT2,
    output logic             halted,
    output logic [CNT_W-1:0] mct_done,
    output logic             done_pulse,
    output logic             abort
);

    localparam int unsigned TMR_MAX = (STRT_PULSE > RST_TMO) ? STRT_PULSE : RST_TMO;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    mon_state_t       state, state_nxt;
    logic             t12_q, t12_rise, gojam_seen, accept;
    logic [CNT_W-1:0] step_n, mct_inc;
    logic             tmr_load, tmr_pulse, tmr_last;
    logic [TMR_W-1:0] tmr_val;
    logic             done_set, abort_set, cnt_clr, cnt_inc, n_load;

    // One timer serves both the start-pulse width and the restart timeout;
    // the two uses never overlap in time.
    agc_pulse_timer #(.W(TMR_W)) u_tmr (
        .CLOCK    (CLOCK),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .pulse    (tmr_pulse),
        .last     (tmr_last)
    );

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) state <= RUNNING;
        else     state <= state_nxt;
    end

    always_comb begin
        accept   = cmd_valid & cmd_ready;
        t12_rise = T12 & ~t12_q;
        mct_inc  = mct_done + CNT_W'(1);
    end

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        done_set  = 1'b0;
        abort_set = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        n_load    = 1'b0;
        unique case (state)
            RUNNING: if (accept) begin
                case (cmd_op)
                    CMD_RUN:            done_set = 1'b1;
                    CMD_STOP, CMD_STEP: state_nxt = STOPPING;
                    default: begin
                        state_nxt = RESTART;
                        tmr_load  = 1'b1;
                        tmr_val   = TMR_W'(RST_TMO);
                    end
                endcase
            end
            STOPPING: if (STOPA) begin
                state_nxt = HALTED;
                done_set  = 1'b1;
            end
            HALTED: if (accept) begin
                case (cmd_op)
                    CMD_RUN:  state_nxt = RUNNING;
                    CMD_STOP: done_set = 1'b1;
                    CMD_STEP: begin
                        cnt_clr = 1'b1;
                        if (cmd_count == '0) begin
                            done_set = 1'b1;
                        end else begin
                            n_load    = 1'b1;
                            state_nxt = STEP_PULSE;
                            tmr_load  = 1'b1;
                            tmr_val   = TMR_W'(STRT_PULSE);
                        end
                    end
                    default: begin
                        state_nxt = RESTART;
                        tmr_load  = 1'b1;
                        tmr_val   = TMR_W'(RST_TMO);
                    end
                endcase
            end
            STEP_PULSE: begin
                if (GOJAM) begin
                    state_nxt = HALTED;
                    abort_set = 1'b1;
                end else if (tmr_last) begin
                    state_nxt = STEP_WAIT;
                end
            end
            // GOJAM outranks a coincident T12 rise, so the count is not bumped.
            STEP_WAIT: begin
                if (GOJAM) begin
                    state_nxt = HALTED;
                    abort_set = 1'b1;
                end else if (t12_rise) begin
                    cnt_inc = 1'b1;
                    if (mct_inc == step_n) begin
                        state_nxt = STEP_STOP;
                    end else begin
                        state_nxt = STEP_PULSE;
                        tmr_load  = 1'b1;
                        tmr_val   = TMR_W'(STRT_PULSE);
                    end
                end
            end
            STEP_STOP: begin
                if (GOJAM) begin
                    state_nxt = HALTED;
                    abort_set = 1'b1;
                end else if (STOPA) begin
                    state_nxt = HALTED;
                    done_set  = 1'b1;
                end
            end
            RESTART: begin
                if (gojam_seen && !GOJAM) begin
                    state_nxt = RUNNING;
                    done_set  = 1'b1;
                end else if (!gojam_seen && !GOJAM && tmr_last) begin
                    state_nxt = HALTED;
                    abort_set = 1'b1;
                end
            end
            default: state_nxt = RUNNING;
        endcase
    end

    always_comb begin
        MSTP      = (state inside {STOPPING, HALTED, STEP_PULSE, STEP_WAIT, STEP_STOP});
        MSTRTP    = (state == STEP_PULSE) & tmr_pulse;
        STRT2     = (state == RESTART);
        halted    = (state == HALTED);
        cmd_ready = (state == RUNNING) || (state == HALTED);
    end

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            t12_q      <= 1'b0;
            gojam_seen <= 1'b0;
            step_n     <= '0;
            mct_done   <= '0;
            done_pulse <= 1'b0;
            abort      <= 1'b0;
        end else begin
            t12_q      <= T12;
            gojam_seen <= (state == RESTART) & (gojam_seen | GOJAM);
            done_pulse <= done_set;
            abort      <= abort_set | (abort & ~accept);
            if (n_load) step_n <= cmd_count;
            if (cnt_clr)      mct_done <= '0;
            else if (cnt_inc) mct_done <= mct_inc;
        end
    end

endmodule
